// File: rtl/rl_pkg.sv
// Shared definitions for the reinforcement-learning action selector.
// Holds the selector FSM state encoding, the 16-bit LFSR feedback taps,
// the default LFSR seed and the helper that sizes the action code.
package rl_pkg;

    // Selector control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fibonacci LFSR feedback bit positions (polynomial taps 16,14,13,11)
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Width of an action code; a single action still needs one bit
    function automatic int act_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rl_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left, advanced only when requested.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset, loads seed
//   adv   - advance the sequence by one step at this edge
//   seed  - reset value (must be nonzero)
//   value - current register contents
module rl_lfsr16
    import rl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] lfsr_r;
    logic        feedback_s;

    assign feedback_s = lfsr_r[LFSR_TAP_A] ^ lfsr_r[LFSR_TAP_B]
                      ^ lfsr_r[LFSR_TAP_C] ^ lfsr_r[LFSR_TAP_D];

    // Shift register: load seed on reset, step on adv, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_r <= seed;
        end else if (adv) begin
            lfsr_r <= {lfsr_r[14:0], feedback_s};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign value = lfsr_r;

endmodule

// File: rtl/epsilon_greedy_selector.sv
// Epsilon-greedy action selector. Accepts one row of unsigned Q-values,
// scans it sequentially for the maximum (lowest index wins ties) and
// returns either the greedy action or a pseudo-random one, drawn from an
// LFSR that steps once per accepted request.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid / in_ready   - request handshake (ready only when idle)
//   q_values              - row; slice i at [i*Q_WIDTH +: Q_WIDTH]
//   epsilon, explore_en   - exploration threshold and enable, latched at accept
//   out_valid / out_ready - result handshake
//   action                - chosen action code
//   max_value             - row maximum (always the true maximum)
//   explored              - action came from the random draw
module epsilon_greedy_selector
    import rl_pkg::*;
#(
    parameter int          NUM_ACTIONS = 4,
    parameter int          Q_WIDTH     = 16,
    parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED,
    localparam int         ACT_W       = act_w(NUM_ACTIONS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_ACTIONS*Q_WIDTH-1:0] q_values,
    input  logic [15:0]                    epsilon,
    input  logic                           explore_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACT_W-1:0]               action,
    output logic [Q_WIDTH-1:0]             max_value,
    output logic                           explored
);

    state_t                         state_r;
    state_t                         state_s;

    logic [NUM_ACTIONS*Q_WIDTH-1:0] q_row_r;
    logic [15:0]                    eps_r;
    logic                           explore_en_r;
    logic [Q_WIDTH-1:0]             best_r;
    logic [ACT_W-1:0]               best_idx_r;
    logic [ACT_W-1:0]               idx_r;

    logic                           out_valid_r;
    logic [ACT_W-1:0]               action_r;
    logic [Q_WIDTH-1:0]             max_value_r;
    logic                           explored_r;

    logic                           accept_s;
    logic                           release_s;
    logic                           scan_last_s;
    logic [Q_WIDTH-1:0]             cur_slice_s;
    logic                           greater_s;
    logic [Q_WIDTH-1:0]             new_best_s;
    logic [ACT_W-1:0]               new_idx_s;
    logic [ACT_W-1:0]               greedy_code_s;
    logic                           explore_s;
    logic [15:0]                    lfsr_value_s;

    assign accept_s    = in_valid && (state_r == IDLE);
    assign release_s   = out_valid_r && out_ready;
    assign scan_last_s = (state_r == SCAN) && (idx_r == ACT_W'(NUM_ACTIONS - 1));
    assign cur_slice_s = q_row_r[int'(idx_r) * Q_WIDTH +: Q_WIDTH];

    // Strictly-greater replacement keeps the lowest index on ties
    assign greater_s   = cur_slice_s > best_r;
    assign new_best_s  = greater_s ? cur_slice_s : best_r;
    assign new_idx_s   = greater_s ? idx_r : best_idx_r;

    // Slice 0 maps to the highest action code
    assign greedy_code_s = ACT_W'(NUM_ACTIONS - 1) - new_idx_s;

    // The LFSR already holds the post-advance draw r throughout SCAN
    assign explore_s = explore_en_r && (lfsr_value_s < eps_r);

    rl_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (accept_s),
        .seed  (LFSR_SEED),
        .value (lfsr_value_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (scan_last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SCAN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Request capture and sequential maximum search
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_row_r      <= '0;
            eps_r        <= 16'h0000;
            explore_en_r <= 1'b0;
            best_r       <= '0;
            best_idx_r   <= '0;
            idx_r        <= '0;
        end else if (accept_s) begin
            q_row_r      <= q_values;
            eps_r        <= epsilon;
            explore_en_r <= explore_en;
            best_r       <= q_values[Q_WIDTH-1:0];
            best_idx_r   <= '0;
            idx_r        <= ACT_W'(1);
        end else if (state_r == SCAN) begin
            best_r       <= new_best_s;
            best_idx_r   <= new_idx_s;
            idx_r        <= idx_r + ACT_W'(1);
        end else begin
            best_r       <= best_r;
            best_idx_r   <= best_idx_r;
            idx_r        <= idx_r;
        end
    end

    // Result registers: loaded on the final scan step, held until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            action_r    <= '0;
            max_value_r <= '0;
            explored_r  <= 1'b0;
        end else if (scan_last_s) begin
            out_valid_r <= 1'b1;
            action_r    <= explore_s ? lfsr_value_s[ACT_W-1:0] : greedy_code_s;
            max_value_r <= new_best_s;
            explored_r  <= explore_s;
        end else if (release_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign action    = action_r;
    assign max_value = max_value_r;
    assign explored  = explored_r;

endmodule

// File: tb/tb_epsilon_greedy_selector.sv
// Bench for epsilon_greedy_selector: a 4-action and an 8-action instance
// share one clock and reset; results are compared with a reference model.
module tb_epsilon_greedy_selector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         iv4, ir4, ov4, or4, en4, xp4;
    logic [63:0]  q4;
    logic [15:0]  eps4, mx4;
    logic [1:0]   act4;

    logic         iv8, ir8, ov8, or8, en8, xp8;
    logic [127:0] q8;
    logic [15:0]  eps8, mx8;
    logic [2:0]   act8;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] m_lfsr4, m_lfsr8;

    epsilon_greedy_selector #(.NUM_ACTIONS(4), .Q_WIDTH(16), .LFSR_SEED(16'hACE1)) d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .q_values(q4),
        .epsilon(eps4), .explore_en(en4), .out_valid(ov4), .out_ready(or4),
        .action(act4), .max_value(mx4), .explored(xp4));

    epsilon_greedy_selector #(.NUM_ACTIONS(8), .Q_WIDTH(16), .LFSR_SEED(16'hACE1)) d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .q_values(q8),
        .epsilon(eps8), .explore_en(en8), .out_valid(ov8), .out_ready(or8),
        .action(act8), .max_value(mx8), .explored(xp8));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Reference: find the row maximum, then the first slice holding it
    function automatic void ref_model(input int n, input logic [127:0] row, input logic [15:0] r,
                                      input logic [15:0] eps, input logic en,
                                      output int e_act, output int e_max, output int e_xp);
        int best_i;
        e_max = 0;
        for (int i = 0; i < n; i++)
            if (int'(row[i*16 +: 16]) > e_max) e_max = int'(row[i*16 +: 16]);
        best_i = -1;
        for (int i = n - 1; i >= 0; i--)
            if (int'(row[i*16 +: 16]) == e_max) best_i = i;
        if (en && (int'(r) < int'(eps))) begin
            e_act = int'(r) % n;
            e_xp  = 1;
        end else begin
            e_act = n - 1 - best_i;
            e_xp  = 0;
        end
    endfunction

    function automatic logic [127:0] rand_row(input bit narrow);
        logic [127:0] row;
        for (int i = 0; i < 8; i++)
            row[i*16 +: 16] = narrow ? 16'($urandom_range(0, 3)) : 16'($urandom);
        return row;
    endfunction

    function automatic logic get_ov(input int w); return (w == 8) ? ov8 : ov4; endfunction
    function automatic logic get_ir(input int w); return (w == 8) ? ir8 : ir4; endfunction
    function automatic logic get_xp(input int w); return (w == 8) ? xp8 : xp4; endfunction
    function automatic int   get_act(input int w); return (w == 8) ? int'(act8) : int'(act4); endfunction
    function automatic int   get_mx(input int w); return (w == 8) ? int'(mx8) : int'(mx4); endfunction

    // One full request on the chosen instance, with optional result stall
    task automatic do_req(input int w, input logic [127:0] row, input logic [15:0] eps,
                          input logic en, input int hold);
        int n, lat, e_act, e_max, e_xp;
        logic [15:0] r;
        n = (w == 8) ? 8 : 4;
        check_val("in_ready_idle", 32'(get_ir(w)), 32'd1);
        if (w == 8) begin iv8 = 1'b1; q8 = row; eps8 = eps; en8 = en; end
        else begin iv4 = 1'b1; q4 = row[63:0]; eps4 = eps; en4 = en; end
        @(posedge clk); #1;
        // Disturb the inputs right after accept; they must be ignored
        iv4 = 1'b0; iv8 = 1'b0;
        q4 = {$urandom, $urandom}; q8 = {$urandom, $urandom, $urandom, $urandom};
        eps4 = 16'($urandom); eps8 = 16'($urandom); en4 = 1'($urandom); en8 = 1'($urandom);
        if (w == 8) begin m_lfsr8 = lfsr_next(m_lfsr8); r = m_lfsr8; end
        else begin m_lfsr4 = lfsr_next(m_lfsr4); r = m_lfsr4; end
        ref_model(n, row, r, eps, en, e_act, e_max, e_xp);
        lat = 0;
        while (!get_ov(w) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", 32'(lat), 32'(n - 1));
        check_val("action", 32'(get_act(w)), 32'(e_act));
        check_val("max_value", 32'(get_mx(w)), 32'(e_max));
        check_val("explored", 32'(get_xp(w)), 32'(e_xp));
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check_val("hold_valid", 32'(get_ov(w)), 32'd1);
            check_val("hold_in_ready", 32'(get_ir(w)), 32'd0);
            check_val("hold_action", 32'(get_act(w)), 32'(e_act));
            check_val("hold_max", 32'(get_mx(w)), 32'(e_max));
            check_val("hold_explored", 32'(get_xp(w)), 32'(e_xp));
        end
        if (w == 8) or8 = 1'b1; else or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0; or8 = 1'b0;
        check_val("valid_dropped", 32'(get_ov(w)), 32'd0);
        check_val("in_ready_after", 32'(get_ir(w)), 32'd1);
    endtask

    task automatic check_reset_state();
        check_val("rst_valid4", 32'(ov4), 32'd0);
        check_val("rst_action4", 32'(act4), 32'd0);
        check_val("rst_max4", 32'(mx4), 32'd0);
        check_val("rst_expl4", 32'(xp4), 32'd0);
        check_val("rst_ready4", 32'(ir4), 32'd1);
        check_val("rst_valid8", 32'(ov8), 32'd0);
        check_val("rst_ready8", 32'(ir8), 32'd1);
    endtask

    initial begin
        logic [127:0] row;
        rst_n = 1'b0;
        iv4 = 1'b0; or4 = 1'b0; en4 = 1'b0; q4 = '0; eps4 = 16'h0000;
        iv8 = 1'b0; or8 = 1'b0; en8 = 1'b0; q8 = '0; eps8 = 16'h0000;
        m_lfsr4 = 16'hACE1; m_lfsr8 = 16'hACE1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Distinct maximum at slice 1 -> action 2, max 40
        row = '0; row[63:0] = {16'd30, 16'd20, 16'd40, 16'd10};
        do_req(4, row, 16'h0000, 1'b0, 0);
        // All-equal row -> slice 0 wins, action 3
        row = '0; row[63:0] = {16'h0007, 16'h0007, 16'h0007, 16'h0007};
        do_req(4, row, 16'hFFFF, 1'b0, 0);
        // Backpressure for 5 cycles, then an immediate follow-up request
        row = '0; row[63:0] = {16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000};
        do_req(4, row, 16'h8000, 1'b1, 5);
        do_req(4, rand_row(1'b0), 16'h4000, 1'b1, 2);

        // Epsilon zero never explores
        for (int k = 0; k < 1000; k++)
            do_req(8, rand_row(k[0]), 16'h0000, 1'b1, 0);
        // Epsilon max explores on every draw below 16'hFFFF
        for (int k = 0; k < 200; k++)
            do_req(8, rand_row(k[0]), 16'hFFFF, 1'b1, 0);
        // Mixed thresholds on the 4-action instance
        for (int k = 0; k < 100; k++)
            do_req(4, rand_row(k[1]), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        // Reset asserted at the second scan edge aborts the request
        q4 = {16'd5, 16'd6, 16'd7, 16'd8}; en4 = 1'b1; eps4 = 16'hFFFF; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_lfsr4 = 16'hACE1; m_lfsr8 = 16'hACE1;
        check_reset_state();
        repeat (4) begin
            @(posedge clk); #1;
            check_val("no_valid_after_abort", 32'(ov4), 32'd0);
        end
        // The next draw must be the first value after the seed
        do_req(4, rand_row(1'b0), 16'hFFFF, 1'b1, 0);
        do_req(8, rand_row(1'b1), 16'hFFFF, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/epsilon_greedy_selector.md
EPSILON_GREEDY_SELECTOR -- requirements
Module: epsilon_greedy_selector

Interface
REQ-001 Parameter NUM_ACTIONS, default 4, meaning number of Q-values per state; SHALL be a power of two, 2..16.
REQ-002 Parameter Q_WIDTH, default 16, meaning width of each Q-value; values are unsigned.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, meaning LFSR reset value; SHALL be nonzero.
REQ-004 Ports, one per line:
  clk        in   1                   sole clock, rising edge
  rst_n      in   1                   reset, synchronous, active-low
  in_valid   in   1                   request valid
  in_ready   out  1                   block can accept a request
  q_values   in   NUM_ACTIONS*Q_WIDTH Q-row; slice i = bits [i*Q_WIDTH +: Q_WIDTH]
  epsilon    in   16                  exploration threshold, sampled at accept
  explore_en in   1                   exploration enable, sampled at accept
  out_valid  out  1                   result valid
  out_ready  in   1                   consumer accepts result
  action     out  ACT_W               selected action, ACT_W = max(1, clog2(NUM_ACTIONS))
  max_value  out  Q_WIDTH             largest Q-value of the accepted row
  explored   out  1                   1 = action came from the random draw
REQ-005 One clock; reset is synchronous and active-low, named rst_n, sampled on rising clk.

Function
REQ-006 FSM states IDLE, SCAN, DONE; in_ready SHALL equal (state == IDLE).
REQ-007 Accept = in_valid && in_ready at a rising edge. On accept: latch q_values, epsilon and explore_en; advance the LFSR once; load best = slice 0, best_idx = 0, scan index = 1; go to SCAN.
REQ-008 SCAN: at each edge compare slice[idx] against best; replace only if strictly greater; increment idx. After slice NUM_ACTIONS-1 is processed, go to DONE.
REQ-009 Latency: out_valid SHALL rise exactly NUM_ACTIONS-1 edges after the accepting edge. It is independent of data and of exploration.
REQ-010 Ties SHALL resolve to the lowest slice index. This follows from the strict-greater rule.
REQ-011 Greedy action code SHALL be NUM_ACTIONS-1-best_idx. Slice 0 maps to the highest code; this is compatible with the 4-action selector.
REQ-012 LFSR: 16-bit Fibonacci, shifts left, new bit0 = b15^b13^b12^b10 (taps 16,14,13,11). It advances only on accept. Let r be the value after the advance.
REQ-013 Explore condition: latched explore_en && (r < latched epsilon), unsigned. epsilon = 0 SHALL never explore.
REQ-014 When exploring: action = r[ACT_W-1:0] and explored = 1. Otherwise action is the greedy code and explored = 0.
REQ-015 max_value SHALL always be the true row maximum, including when exploring.
REQ-016 DONE: action, max_value and explored SHALL be held stable while out_valid = 1 && out_ready = 0.
REQ-017 out_valid && out_ready at an edge returns the FSM to IDLE. The next request can be accepted one edge later; there is no same-edge re-accept.
REQ-018 Inputs q_values, epsilon and explore_en are don't-care outside the accepting edge; changes mid-SCAN SHALL have no effect.
REQ-019 For NUM_ACTIONS = 2, SCAN lasts one edge.

Reset
REQ-020 rst_n = 0 at an edge: state = IDLE, out_valid = 0, action = 0, max_value = 0, explored = 0, LFSR = LFSR_SEED, internal best/idx = 0.
REQ-021 Reset asserted during SCAN or DONE SHALL abort the request with no out_valid. in_ready = 1 on the first edge after rst_n returns high.

Structure
REQ-022 Shared package rl_pkg SHALL hold: the state enum (IDLE/SCAN/DONE), the LFSR tap constants, the default seed, and a clog2-based ACT_W helper function.
REQ-023 The LFSR SHALL be a sub-module rl_lfsr16 (ports clk, rst_n, adv, seed, value). The FSM and comparator stay in epsilon_greedy_selector.

Verification
REQ-024 N=4, explore_en = 0, slices {10,40,20,30} (slice 0 first) -> after 3 edges out_valid = 1, action = 2, max_value = 40, explored = 0.
REQ-025 N=4, explore_en = 0, all slices = 16'h0007 -> action = 3 (slice 0 wins the tie), max_value = 7.
REQ-026 N=8, explore_en = 1, epsilon = 0, 1000 random rows -> explored always 0 and action matches the greedy model; epsilon = 16'hFFFF -> explored = 1 except when r = 16'hFFFF, action = r[2:0] checked against the LFSR model.
REQ-027 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready = 0; on release, IDLE follows and the next request is accepted.
REQ-028 Reset mid-SCAN (rst_n low at the 2nd SCAN edge) -> no out_valid, all outputs 0, LFSR = seed; the next request's r equals the first value after the seed.
